// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: merges pipeline writebacks with a FIFO of multi-cycle results onto one register-file write port.
// Optional WB_WAW_KILL_EN: a pipeline write cancels older queued results to the same register.
module reg_write_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_addr,
    input  logic [31:0] pipe_data,
    input  logic        mc_valid,
    input  logic [4:0]  mc_addr,
    input  logic [31:0] mc_data,
    output logic        mc_ready,
    input  logic [4:0]  ReadAddr1,
    input  logic [4:0]  ReadAddr2,
    output logic        pending1,
    output logic        pending2,
    output logic        stall_req,
    output logic        RegWrite,
    output logic [4:0]  WriteAddr,
    output logic [31:0] WriteData
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]       r_addr [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [DEPTH-1:0] r_live;
    logic [PW-1:0]    r_wptr, r_rptr;
    logic [CW-1:0]    r_count;
    logic             r_wr;
    logic [4:0]       r_waddr;
    logic [31:0]      r_wdata;

    logic             w_pipe_sel, w_pop, w_push, w_head_wr, w_wr, w_p1, w_p2;
    logic [4:0]       w_addr;
    logic [31:0]      w_data;
    logic [DEPTH-1:0] w_kill;

    assign mc_ready   = !reset && (r_count != CW'(DEPTH));
    assign stall_req  = r_count == CW'(DEPTH);
    assign w_pipe_sel = pipe_we && (pipe_addr != 5'd0);
    assign w_pop      = !w_pipe_sel && (r_count != '0);
    assign w_push     = mc_valid && mc_ready && (mc_addr != 5'd0);
    // A dead head is consumed without producing a write.
    assign w_head_wr  = w_pop && r_live[r_rptr];
    assign w_wr       = w_pipe_sel || w_head_wr;
    assign w_addr     = w_pipe_sel ? pipe_addr : w_head_wr ? r_addr[r_rptr] : 5'd0;
    assign w_data     = w_pipe_sel ? pipe_data : w_head_wr ? r_data[r_rptr] : 32'd0;

    always_comb begin
        w_kill = '0;
`ifdef WB_WAW_KILL_EN
        for (int i = 0; i < DEPTH; i++)
            w_kill[i] = w_pipe_sel && (r_addr[i] == pipe_addr);
`endif
    end

    always_comb begin
        w_p1 = 1'b0;
        w_p2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            w_p1 = w_p1 | (r_live[i] && (r_addr[i] == ReadAddr1));
            w_p2 = w_p2 | (r_live[i] && (r_addr[i] == ReadAddr2));
        end
    end

    assign pending1 = w_p1 && (ReadAddr1 != 5'd0);
    assign pending2 = w_p2 && (ReadAddr2 != 5'd0);

    // Push is applied last so a same-cycle mc result survives a kill to its address.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_live  <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_wr    <= 1'b0;
            r_waddr <= 5'd0;
            r_wdata <= 32'd0;
        end else begin
            r_live <= r_live & ~w_kill;
            if (w_pop) begin
                r_live[r_rptr] <= 1'b0;
                r_rptr         <= r_rptr + 1'b1;
            end
            if (w_push) begin
                r_addr[r_wptr] <= mc_addr;
                r_data[r_wptr] <= mc_data;
                r_live[r_wptr] <= 1'b1;
                r_wptr         <= r_wptr + 1'b1;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            r_wr    <= w_wr;
            r_waddr <= w_addr;
            r_wdata <= w_data;
        end
    end

    assign RegWrite  = r_wr;
    assign WriteAddr = r_waddr;
    assign WriteData = r_wdata;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: directed vector table plus hand sequences for reset, queue fill and drain order.
module tb_reg_write_arbiter;
`ifdef WB_WAW_KILL_EN
    localparam bit KILL = 1'b1;
`else
    localparam bit KILL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, pipe_we, mc_valid, mc_ready, pending1, pending2, stall_req, RegWrite;
    logic [4:0]  pipe_addr, mc_addr, ReadAddr1, ReadAddr2, WriteAddr;
    logic [31:0] pipe_data, mc_data, WriteData;

    always #5 clk = ~clk;

    reg_write_arbiter #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
        .mc_valid(mc_valid), .mc_addr(mc_addr), .mc_data(mc_data), .mc_ready(mc_ready),
        .ReadAddr1(ReadAddr1), .ReadAddr2(ReadAddr2), .pending1(pending1), .pending2(pending2),
        .stall_req(stall_req), .RegWrite(RegWrite), .WriteAddr(WriteAddr), .WriteData(WriteData)
    );

    typedef struct {
        logic        rst, we;
        logic [4:0]  pa;
        logic [31:0] pd;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic [4:0]  r1, r2;
        logic        ew;
        logic [4:0]  ewa;
        logic [31:0] ewd;
        logic        erdy, est, ep1, ep2;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic vec_t mk(input logic rst, we, input logic [4:0] pa, input logic [31:0] pd,
                                input logic mv, input logic [4:0] ma, input logic [31:0] md,
                                input logic [4:0] r1, r2, input logic ew, input logic [4:0] ewa,
                                input logic [31:0] ewd, input logic erdy, est, ep1, ep2);
        vec_t v;
        v.rst = rst; v.we = we; v.pa = pa; v.pd = pd; v.mv = mv; v.ma = ma; v.md = md;
        v.r1 = r1; v.r2 = r2; v.ew = ew; v.ewa = ewa; v.ewd = ewd;
        v.erdy = erdy; v.est = est; v.ep1 = ep1; v.ep2 = ep2;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, we, input logic [4:0] pa, input logic [31:0] pd,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md,
                         input logic [4:0] r1, r2);
        reset = rst; pipe_we = we; pipe_addr = pa; pipe_data = pd;
        mc_valid = mv; mc_addr = ma; mc_data = md; ReadAddr1 = r1; ReadAddr2 = r2;
    endtask

    vec_t vt[36];

    initial begin
        int acc, got;
        vt[0]  = mk(0,0,0,0,0,0,0,0,0,        0,0,0,1,0,0,0);
        vt[1]  = mk(0,0,0,0,0,0,0,7,5,        0,0,0,1,0,0,0);
        vt[2]  = mk(0,0,0,0,0,0,0,7,5,        0,0,0,1,0,0,0);
        vt[3]  = mk(0,1,5,'h1234,1,7,'hBEEF,7,5, 0,0,0,1,0,0,0);
        vt[4]  = mk(0,0,0,0,0,0,0,7,5,        1,5,'h1234,1,0,1,0);
        vt[5]  = mk(0,0,0,0,0,0,0,7,5,        1,7,'hBEEF,1,0,0,0);
        vt[6]  = mk(0,0,0,0,0,0,0,7,5,        0,0,0,1,0,0,0);
        vt[7]  = mk(0,1,1,'h11,1,2,'h21,2,3,  0,0,0,1,0,0,0);
        vt[8]  = mk(0,1,1,'h12,1,3,'h22,2,3,  1,1,'h11,1,0,1,0);
        vt[9]  = mk(0,1,1,'h13,1,4,'h23,2,3,  1,1,'h12,1,0,1,1);
        vt[10] = mk(0,1,1,'h14,1,5,'h24,2,3,  1,1,'h13,1,0,1,1);
        vt[11] = mk(0,1,1,'h15,1,6,'h25,2,3,  1,1,'h14,0,1,1,1);
        vt[12] = mk(0,0,0,0,1,6,'h25,2,3,     1,1,'h15,0,1,1,1);
        vt[13] = mk(0,0,0,0,0,0,0,2,3,        1,2,'h21,1,0,0,1);
        vt[14] = mk(0,0,0,0,0,0,0,2,3,        1,3,'h22,1,0,0,0);
        vt[15] = mk(0,0,0,0,0,0,0,2,3,        1,4,'h23,1,0,0,0);
        vt[16] = mk(0,0,0,0,0,0,0,2,3,        1,5,'h24,1,0,0,0);
        vt[17] = mk(0,0,0,0,0,0,0,2,3,        0,0,0,1,0,0,0);
        vt[18] = mk(0,0,0,0,1,8,'h88,8,0,     0,0,0,1,0,0,0);
        vt[19] = mk(0,1,0,'hDEAD,0,0,0,8,0,   0,0,0,1,0,1,0);
        vt[20] = mk(0,0,0,0,0,0,0,8,0,        1,8,'h88,1,0,0,0);
        vt[21] = mk(0,0,0,0,0,0,0,8,0,        0,0,0,1,0,0,0);
        vt[22] = mk(0,0,0,0,1,9,'hAAAA,9,0,   0,0,0,1,0,0,0);
        vt[23] = mk(0,1,9,'h5555,0,0,0,9,0,   0,0,0,1,0,1,0);
        vt[24] = mk(0,0,0,0,0,0,0,9,0,        1,9,'h5555,1,0,!KILL,0);
        vt[25] = mk(0,0,0,0,0,0,0,9,0,        !KILL,KILL ? 5'd0 : 5'd9,KILL ? 32'h0 : 32'hAAAA,1,0,0,0);
        vt[26] = mk(0,0,0,0,0,0,0,9,0,        0,0,0,1,0,0,0);
        vt[27] = mk(0,0,0,0,1,0,'hFFFF,0,0,   0,0,0,1,0,0,0);
        vt[28] = mk(0,0,0,0,0,0,0,0,0,        0,0,0,1,0,0,0);
        vt[29] = mk(0,0,0,0,0,0,0,0,0,        0,0,0,1,0,0,0);
        vt[30] = mk(0,1,1,'h1,1,10,'hA0,10,11, 0,0,0,1,0,0,0);
        vt[31] = mk(0,1,1,'h2,1,11,'hB0,10,11, 1,1,'h1,1,0,1,0);
        vt[32] = mk(1,1,1,'h3,1,12,'hC0,10,11, 1,1,'h2,0,0,1,1);
        vt[33] = mk(0,0,0,0,0,0,0,10,11,      0,0,0,1,0,0,0);
        vt[34] = mk(0,0,0,0,0,0,0,10,11,      0,0,0,1,0,0,0);
        vt[35] = mk(0,0,0,0,0,0,0,10,11,      0,0,0,1,0,0,0);

        drive(1,0,0,0,0,0,0,0,0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", 64'({RegWrite, WriteAddr, WriteData, stall_req, mc_ready}), 64'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 36; i++) begin
            drive(vt[i].rst, vt[i].we, vt[i].pa, vt[i].pd, vt[i].mv, vt[i].ma, vt[i].md, vt[i].r1, vt[i].r2);
            @(negedge clk);
            chk($sformatf("vec%0d {wr,addr,data,rdy,stall,p1,p2}", i),
                64'({RegWrite, WriteAddr, WriteData, mc_ready, stall_req, pending1, pending2}),
                64'({vt[i].ew, vt[i].ewa, vt[i].ewd, vt[i].erdy, vt[i].est, vt[i].ep1, vt[i].ep2}));
            @(posedge clk);
            #1;
        end

        acc = 0;
        for (int c = 0; c < 6; c++) begin
            drive(0, 1, 5'd1, 32'(c), 1, 5'(20 + acc), 32'(100 + acc), 0, 0);
            @(negedge clk);
            if (mc_ready) acc++;
            @(posedge clk);
            #1;
        end
        chk("fill_accepted", 64'(acc), 64'd4);
        drive(0,0,0,0,0,0,0,0,0);
        @(negedge clk);
        chk("fill_stall_ready", 64'({stall_req, mc_ready}), 64'b10);

        got = 0;
        for (int c = 0; c < 12 && got < 4; c++) begin
            if (c > 0) @(negedge clk);
            if (RegWrite && WriteAddr != 5'd1) begin
                chk("drain_order", 64'({WriteAddr, WriteData}), 64'({5'(20 + got), 32'(100 + got)}));
                got++;
            end
            @(posedge clk);
            #1;
        end
        chk("drain_count", 64'(got), 64'd4);
        @(negedge clk);
        chk("drained_stall_ready", 64'({stall_req, mc_ready}), 64'b01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
